// File: rtl/shot_sequencer.sv
// Cannon-shot sequencer: fire edge -> per-tick ballistic flight -> result hold -> idle, with scoring.
// Define SHOT_SCORE_BCD_EN for a 4-digit packed BCD score (saturates at 9999) instead of binary.
module shot_sequencer #(
   parameter int TICK_DIV     = 50000000,
   parameter int X_INIT       = 213,
   parameter int Y_INIT       = 472,
   parameter int GROUND_Y     = 472,
   parameter int Y_MIN        = 51,
   parameter int X_MAX        = 775,
   parameter int TGT_XL       = 650,
   parameter int TGT_XR       = 675,
   parameter int GRAV         = 1,
   parameter int RESULT_TICKS = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fire,
   input  logic [3:0]  vx_sel,
   input  logic [3:0]  vy_sel,
   output logic [9:0]  proj_x,
   output logic [9:0]  proj_y,
   output logic        busy,
   output logic        hit_pulse,
   output logic        miss_pulse,
   output logic        last_hit,
   output logic [15:0] score
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int RES_W = (RESULT_TICKS > 1) ? $clog2(RESULT_TICKS) : 1;

   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [RES_W-1:0]  RES_LAST = RES_W'(RESULT_TICKS - 1);
   localparam logic [9:0]        X0       = 10'(X_INIT);
   localparam logic [9:0]        Y0       = 10'(Y_INIT);
   localparam logic [10:0]       XMAX11   = 11'(X_MAX);
   localparam logic [10:0]       TGTL11   = 11'(TGT_XL);
   localparam logic [10:0]       TGTR11   = 11'(TGT_XR);
   localparam logic signed [10:0] GROUND_S = 11'(GROUND_Y);
   localparam logic signed [10:0] YMIN_S   = 11'(Y_MIN);
   localparam logic signed [7:0]  GRAV8    = 8'(GRAV);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FLIGHT,
      S_RESULT
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [RES_W-1:0]   res_cnt_q, res_cnt_d;
   logic               fire_q, fire_d;
   logic [3:0]         vx_q, vx_d;
   logic signed [7:0]  vy_q, vy_d;
   logic [9:0]         proj_x_q, proj_x_d;
   logic [9:0]         proj_y_q, proj_y_d;
   logic               hit_pulse_q, hit_pulse_d;
   logic               miss_pulse_q, miss_pulse_d;
   logic               last_hit_q, last_hit_d;
   logic [15:0]        score_q, score_d;

   logic               tick;
   logic               fire_edge;
   logic [10:0]        x_next;
   logic signed [10:0] y_next;
   logic               on_target;
   logic [15:0]        score_inc;

`ifdef SHOT_SCORE_BCD_EN
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (v[i*4 +: 4] == 4'd9) begin
               r[i*4 +: 4] = 4'd0;
            end else begin
               r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   assign score_inc = (score_q == 16'h9999) ? score_q : bcd_inc(score_q);
`else
   assign score_inc = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
`endif

   assign tick      = (cnt_q == CNT_LAST);
   assign fire_edge = fire & ~fire_q;
   assign x_next    = {1'b0, proj_x_q} + {7'd0, vx_q};
   // vy_cur is signed: once it goes negative the projectile falls
   assign y_next    = $signed({1'b0, proj_y_q}) - $signed({{3{vy_q[7]}}, vy_q});
   assign on_target = (x_next >= TGTL11) && (x_next <= TGTR11);

   always_comb begin
      state_d      = state_q;
      cnt_d        = tick ? '0 : cnt_q + 1'b1;
      res_cnt_d    = res_cnt_q;
      fire_d       = fire;
      vx_d         = vx_q;
      vy_d         = vy_q;
      proj_x_d     = proj_x_q;
      proj_y_d     = proj_y_q;
      hit_pulse_d  = 1'b0;
      miss_pulse_d = 1'b0;
      last_hit_d   = last_hit_q;
      score_d      = score_q;

      unique case (state_q)
         S_IDLE: begin
            proj_x_d = X0;
            proj_y_d = Y0;
            if (fire_edge) begin
               // restart the tick phase so the first step is a full tick away
               vx_d      = vx_sel;
               vy_d      = {4'd0, vy_sel};
               cnt_d     = '0;
               res_cnt_d = '0;
               state_d   = S_FLIGHT;
            end
         end
         S_FLIGHT: begin
            if (tick) begin
               vy_d = vy_q - GRAV8;
               if (x_next >= XMAX11) begin
                  miss_pulse_d = 1'b1;
                  last_hit_d   = 1'b0;
                  res_cnt_d    = '0;
                  state_d      = S_RESULT;
               end else if (y_next >= GROUND_S) begin
                  proj_x_d  = x_next[9:0];
                  proj_y_d  = 10'(GROUND_Y);
                  res_cnt_d = '0;
                  state_d   = S_RESULT;
                  if (on_target) begin
                     hit_pulse_d = 1'b1;
                     last_hit_d  = 1'b1;
                     score_d     = score_inc;
                  end else begin
                     miss_pulse_d = 1'b1;
                     last_hit_d   = 1'b0;
                  end
               end else if (y_next < YMIN_S) begin
                  proj_x_d = x_next[9:0];
                  proj_y_d = 10'(Y_MIN);
               end else begin
                  proj_x_d = x_next[9:0];
                  proj_y_d = y_next[9:0];
               end
            end
         end
         S_RESULT: begin
            if (tick) begin
               if (res_cnt_q == RES_LAST) begin
                  proj_x_d  = X0;
                  proj_y_d  = Y0;
                  res_cnt_d = '0;
                  state_d   = S_IDLE;
               end else begin
                  res_cnt_d = res_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         res_cnt_q    <= '0;
         fire_q       <= 1'b0;
         vx_q         <= '0;
         vy_q         <= '0;
         proj_x_q     <= X0;
         proj_y_q     <= Y0;
         hit_pulse_q  <= 1'b0;
         miss_pulse_q <= 1'b0;
         last_hit_q   <= 1'b0;
         score_q      <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         res_cnt_q    <= res_cnt_d;
         fire_q       <= fire_d;
         vx_q         <= vx_d;
         vy_q         <= vy_d;
         proj_x_q     <= proj_x_d;
         proj_y_q     <= proj_y_d;
         hit_pulse_q  <= hit_pulse_d;
         miss_pulse_q <= miss_pulse_d;
         last_hit_q   <= last_hit_d;
         score_q      <= score_d;
      end
   end

   assign proj_x     = proj_x_q;
   assign proj_y     = proj_y_q;
   assign busy       = (state_q != S_IDLE);
   assign hit_pulse  = hit_pulse_q;
   assign miss_pulse = miss_pulse_q;
   assign last_hit   = last_hit_q;
   assign score      = score_q;

endmodule

// File: tb/tb_shot_sequencer.sv
// Scoreboard bench for shot_sequencer: a trajectory model queues one expected state per tick.
module tb_shot_sequencer;

   localparam int TD       = 4;
   localparam int XI       = 213;
   localparam int YI       = 472;
   localparam int GND      = 472;
   localparam int YMN      = 400;
   localparam int XMX      = 400;
   localparam int TL       = 260;
   localparam int TR       = 270;
   localparam int RES_T    = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        fire = 1'b0;
   logic [3:0]  vx_sel = '0;
   logic [3:0]  vy_sel = '0;
   logic [9:0]  proj_x, proj_y;
   logic        busy, hit_pulse, miss_pulse, last_hit;
   logic [15:0] score;

   typedef struct {
      int x;
      int y;
      bit hit;
      bit miss;
      bit last;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   exp_score = 0;
   bit   exp_last_hit = 1'b0;

   always #5 clk = ~clk;

   shot_sequencer #(
      .TICK_DIV(TD), .X_INIT(XI), .Y_INIT(YI), .GROUND_Y(GND), .Y_MIN(YMN),
      .X_MAX(XMX), .TGT_XL(TL), .TGT_XR(TR), .GRAV(1), .RESULT_TICKS(RES_T)
   ) dut (
      .clk(clk), .reset(reset), .fire(fire), .vx_sel(vx_sel), .vy_sel(vy_sel),
      .proj_x(proj_x), .proj_y(proj_y), .busy(busy), .hit_pulse(hit_pulse),
      .miss_pulse(miss_pulse), .last_hit(last_hit), .score(score)
   );

   // Expected per-tick position and pulses for one shot
   task automatic model_shot(input int vx, input int vy);
      int x, y, v, xn, yn;
      exp_t e;
      x = XI; y = YI; v = vy;
      for (int t = 1; t < 64; t++) begin
         xn = x + vx;
         yn = y - v;
         v  = v - 1;
         e.hit = 0; e.miss = 0; e.last = 0;
         if (xn >= XMX) begin
            e.miss = 1; e.last = 1; exp_last_hit = 0;
         end else if (yn >= GND) begin
            x = xn; y = GND; e.last = 1;
            if (xn >= TL && xn <= TR) begin
               e.hit = 1; exp_last_hit = 1; exp_score++;
            end else begin
               e.miss = 1; exp_last_hit = 0;
            end
         end else if (yn < YMN) begin
            x = xn; y = YMN;
         end else begin
            x = xn; y = yn;
         end
         e.x = x; e.y = y;
         sb.push_back(e);
         if (e.last) break;
      end
   endtask

   // Fires one shot and checks up to max_ticks flight ticks; completes the result phase if it resolved
   task automatic run_shot(input int vx, input int vy, input bit toggle, input int max_ticks);
      exp_t e;
      bit   done;
      int   ntog;
      int   nt;
      done = 0; ntog = 0; nt = 0;
      vx_sel = 4'(vx);
      vy_sel = 4'(vy);
      model_shot(vx, vy);
      fire = 1'b0;
      @(negedge clk);
      fire = 1'b1;
      @(negedge clk);
      while (!done && nt < max_ticks) begin
         nt++;
         for (int c = 0; c < TD; c++) begin
            @(negedge clk);
            if (toggle && c == 1 && ntog < 4) begin
               fire = ~fire;
               ntog++;
            end
         end
         n_tests++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_underflow tick %0d: DUT still flying, no expected entry", nt);
            done = 1;
         end else begin
            e = sb.pop_front();
            if (proj_x !== 10'(e.x) || proj_y !== 10'(e.y)) begin
               n_fail++;
               $display("FAIL pos tick %0d: got (%0d,%0d) want (%0d,%0d)", nt, proj_x, proj_y, e.x, e.y);
            end
            n_tests++;
            if (hit_pulse !== e.hit || miss_pulse !== e.miss) begin
               n_fail++;
               $display("FAIL pulses tick %0d: got hit=%0b miss=%0b want hit=%0b miss=%0b",
                        nt, hit_pulse, miss_pulse, e.hit, e.miss);
            end
            n_tests++;
            if (busy !== 1'b1) begin
               n_fail++;
               $display("FAIL busy tick %0d: got %0b want 1", nt, busy);
            end
            done = e.last;
         end
      end
      if (done) begin
         @(negedge clk);
         n_tests++;
         if (hit_pulse !== 1'b0 || miss_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL pulse_width: got hit=%0b miss=%0b want 0 0", hit_pulse, miss_pulse);
         end
         n_tests++;
         if (score !== 16'(exp_score) || last_hit !== exp_last_hit) begin
            n_fail++;
            $display("FAIL score: got score=%0h last_hit=%0b want %0h %0b", score, last_hit, exp_score, exp_last_hit);
         end
         for (int c = 0; c < TD - 1; c++) begin
            @(negedge clk);
            if (toggle && c == 0) fire = 1'b0;
            if (toggle && c == 1) fire = 1'b1;
         end
         n_tests++;
         if (busy !== 1'b1 || proj_x !== 10'(e.x) || proj_y !== 10'(e.y)) begin
            n_fail++;
            $display("FAIL result_hold: got busy=%0b (%0d,%0d) want 1 (%0d,%0d)", busy, proj_x, proj_y, e.x, e.y);
         end
         repeat (TD) @(negedge clk);
         n_tests++;
         if (busy !== 1'b0 || proj_x !== 10'(XI) || proj_y !== 10'(YI)) begin
            n_fail++;
            $display("FAIL return_idle: got busy=%0b (%0d,%0d) want 0 (%0d,%0d)", busy, proj_x, proj_y, XI, YI);
         end
      end
      fire = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset;
      bit pulse_seen;
      pulse_seen = 0;
      reset = 1'b1;
      fire  = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (hit_pulse || miss_pulse || busy) pulse_seen = 1;
      end
      n_tests++;
      if (proj_x !== 10'(XI) || proj_y !== 10'(YI)) begin
         n_fail++;
         $display("FAIL reset_pos: got (%0d,%0d) want (%0d,%0d)", proj_x, proj_y, XI, YI);
      end
      n_tests++;
      if (score !== 16'd0 || last_hit !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_score: got score=%0h last_hit=%0b want 0 0", score, last_hit);
      end
      n_tests++;
      if (pulse_seen) begin
         n_fail++;
         $display("FAIL reset_idle: got busy/pulse activity want none");
      end
   endtask

   task automatic test_lob_miss;
      run_shot(3, 6, 0, 64);
   endtask

   task automatic test_lob_hit;
      run_shot(4, 6, 0, 64);
   endtask

   task automatic test_right_edge;
      run_shot(15, 15, 0, 64);
   endtask

   task automatic test_zero_vy;
      run_shot(5, 0, 0, 64);
   endtask

   task automatic test_fire_ignored;
      run_shot(4, 6, 1, 64);
   endtask

   task automatic test_async_reset;
      run_shot(4, 6, 0, 5);
      #1 reset = 1'b1;
      #1;
      n_tests++;
      if (proj_x !== 10'(XI) || proj_y !== 10'(YI) || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset_pos: got busy=%0b (%0d,%0d) want 0 (%0d,%0d)", busy, proj_x, proj_y, XI, YI);
      end
      n_tests++;
      if (score !== 16'd0 || last_hit !== 1'b0 || hit_pulse !== 1'b0 || miss_pulse !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset_flags: got score=%0h last=%0b hit=%0b miss=%0b want all 0",
                  score, last_hit, hit_pulse, miss_pulse);
      end
      sb.delete();
      exp_score    = 0;
      exp_last_hit = 0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      run_shot(4, 6, 0, 64);
   endtask

   initial begin
      test_reset();
      test_lob_miss();
      test_lob_hit();
      test_right_edge();
      test_zero_vy();
      test_fire_ignored();
      test_async_reset();
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/shot_sequencer.md
Name: shot_sequencer

Overview:
- Controls one cannon shot on the projectile display datapath: accepts a fire request, latches launch velocities, and steps the projectile position once per game tick.
- Detects landing, off-screen exit and target hits; keeps the player score.
- Sits between the board buttons/switches and the VGA pixel painter, which reads proj_x/proj_y only.

Parameters:
- TICK_DIV, 50000000, clk cycles per game tick (benches use 4)
- X_INIT, 213, launch x (pixels)
- Y_INIT, 472, launch y (pixels)
- GROUND_Y, 472, landing line; y_next >= GROUND_Y means landed
- Y_MIN, 51, ceiling; y is clamped here
- X_MAX, 775, right edge; x_next >= X_MAX means miss
- TGT_XL, 650, target left x (inclusive)
- TGT_XR, 675, target right x (inclusive)
- GRAV, 1, vertical velocity decrement per tick
- RESULT_TICKS, 2, ticks the result is held before returning to idle

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- fire  in  1  fire button level, already debounced
- vx_sel  in  4  horizontal speed, pixels/tick, unsigned
- vy_sel  in  4  initial upward speed, pixels/tick, unsigned
- proj_x  out  10  projectile x
- proj_y  out  10  projectile y
- busy  out  1  high in FLIGHT and RESULT
- hit_pulse  out  1  one-cycle pulse on target hit
- miss_pulse  out  1  one-cycle pulse on miss
- last_hit  out  1  result of the most recent shot
- score  out  16  hit count

Behaviour:
- Reset values:
  - proj_x = X_INIT, proj_y = Y_INIT.
  - busy, hit_pulse, miss_pulse and last_hit = 0.
  - score = 0, state = IDLE, tick counter = 0, fire_q = 0.
- Fire detect:
  - fire_q registers fire every cycle; edge = fire & ~fire_q.
  - An edge is honoured only in IDLE. Edges in FLIGHT or RESULT are dropped and never queued.
- Tick:
  - A counter runs 0..TICK_DIV-1. tick is high for one cycle when the counter reaches TICK_DIV-1, then the counter wraps to 0.
  - The counter is cleared on the cycle a fire edge is accepted, so the first update lands exactly TICK_DIV cycles after FLIGHT is entered.
- IDLE:
  - proj_x/proj_y are held at X_INIT/Y_INIT.
  - On an edge: latch vx = vx_sel and vy_cur = vy_sel into an 8-bit signed register, then go to FLIGHT next cycle with busy = 1.
- FLIGHT, on each tick:
  - x_next = proj_x + vx.
  - y_next = proj_y - vy_cur, 11-bit signed.
  - vy_cur <= vy_cur - GRAV.
  - Decision, in priority order:
    1. x_next >= X_MAX: miss. proj_x is held, miss_pulse fires, last_hit = 0, go to RESULT.
    2. y_next >= GROUND_Y: landed. proj_x = x_next, proj_y = GROUND_Y.
       - If TGT_XL <= x_next <= TGT_XR: hit_pulse fires, last_hit = 1, score increments.
       - Otherwise: miss_pulse fires, last_hit = 0.
       - Go to RESULT.
    3. y_next < Y_MIN: proj_y = Y_MIN, proj_x = x_next, flight continues.
    4. Otherwise: proj_x = x_next, proj_y = y_next.
  - The pulse is asserted in the same cycle the register update is seen.
- Flight length: with GRAV = 1 and no clamp or exit, a shot lands after 2*vy_sel + 1 ticks. vy_sel = 0 lands on tick 1.
- RESULT:
  - The final position is held for RESULT_TICKS ticks.
  - Then: proj_x/proj_y return to X_INIT/Y_INIT, busy = 0, go to IDLE.
  - last_hit is kept until the next shot resolves.
- Score: binary, saturating at 16'hFFFF. A hit while saturated leaves score unchanged but still pulses hit_pulse.
- Reset mid-operation: everything returns to reset values immediately and asynchronously. No pulse is emitted.
- No multipliers or dividers; all arithmetic is incremental.

Optional Feature:
- Macro: SHOT_SCORE_BCD_EN.
- Defined: score is 4 packed BCD digits, [15:12] being the thousands digit, for the seven-segment driver.
  - A hit increments with decimal carry, e.g. 0x0009 -> 0x0010.
  - The score saturates at 0x9999.
- Undefined: the binary saturating counter described above.

Test Plan:
- Reset, then hold fire low for 100 cycles -> proj = (213, 472), busy = 0, score = 0, no pulses.
- Lob miss: TICK_DIV = 4, vx = 4, vy = 6, fire edge -> after 13 ticks proj = (265, 472), miss_pulse once, score = 0. At tick 6, proj = (237, 451).
- Lob hit: same stimulus with TGT_XL = 260, TGT_XR = 270 -> hit_pulse once at tick 13, last_hit = 1, score = 1 (BCD build: 0x0001). Then return to (213, 472) after RESULT_TICKS ticks.
- Right-edge miss: X_MAX = 400, vx = 15, vy = 15 -> at tick 13 x_next = 408, miss_pulse, proj_x held at 393, no ground landing.
- Fire ignored: toggle fire 3 times during FLIGHT and RESULT -> exactly one shot resolves, busy stays high, score changes by at most 1.
- Async reset at tick 5 of a flight -> outputs at reset values within the same cycle. A new fire works normally afterwards with score = 0.
